fir_coeff_ctrl: RTL and testbench
=================================

FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 51, the filter tap count.
REQ-002 SHALL have parameter CW, default 16, the coefficient width (signed Q1.15).
REQ-003 SHALL have parameter AW, default 6, the coefficient address width.
REQ-004 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: cfg_start  input  1  begin a new shadow load; clears the load count.
REQ-007 SHALL have port: cfg_valid  input  1  host coefficient word valid.
REQ-008 SHALL have port: cfg_ready  output  1  ready to accept a host word.
REQ-009 SHALL have port: cfg_data  input  CW  coefficient word, in tap order from tap 0.
REQ-010 SHALL have port: cfg_commit  input  1  request transfer of the shadow bank to the filter.
REQ-011 SHALL have port: cfg_err  output  1  one-cycle pulse; commit rejected.
REQ-012 SHALL have port: busy  output  1  high in states WAIT and WRITE.
REQ-013 SHALL have port: samp_valid_in  input  1  upstream sample strobe.
REQ-014 SHALL have port: samp_valid_out  output  1  gated sample strobe to the filter.
REQ-015 SHALL have port: coef_we  output  1  filter coefficient write enable.
REQ-016 SHALL have port: coef_addr  output  AW  filter coefficient address.
REQ-017 SHALL have port: coef_data  output  CW  filter coefficient data.
REQ-018 SHALL have port: swap_done  output  1  one-cycle pulse; transfer complete.
REQ-019 SHALL have port: drop_cnt  output  8  saturating count of samples blocked during WRITE.

Function
REQ-020 SHALL implement an FSM with states IDLE, LOAD, FULL, WAIT and WRITE.
REQ-021 IDLE: cfg_start SHALL move the FSM to LOAD with load count 0.
REQ-022 LOAD: cfg_ready=1, and each cycle with cfg_valid&&cfg_ready SHALL write cfg_data to shadow[count] and increment count.
REQ-023 LOAD SHALL move to FULL on the cycle the NLOAD-th word is accepted; cfg_ready=0 from then on.
REQ-024 cfg_start in LOAD or FULL SHALL restart the load at count 0 and takes priority over a simultaneous cfg_valid.
REQ-025 cfg_commit in IDLE or LOAD SHALL pulse cfg_err the next cycle with no state change.
REQ-026 cfg_commit in FULL SHALL move to WAIT; cfg_start and cfg_commit in WAIT or WRITE SHALL be ignored.
REQ-027 WAIT SHALL pass samp_valid_out=samp_valid_in and SHALL enter WRITE on the cycle after the first cycle with samp_valid_in=0.
REQ-028 WRITE SHALL assert coef_we for exactly NTAPS consecutive cycles with coef_addr 0..NTAPS-1 ascending, with coef_data taken from the shadow entry for that address.
REQ-029 During WRITE, samp_valid_out SHALL be 0, and each samp_valid_in=1 SHALL increment drop_cnt, saturating at 255.
REQ-030 swap_done SHALL pulse on the cycle after the last write, and the FSM SHALL return to IDLE on that cycle.
REQ-031 The shadow bank SHALL be retained after a transfer; a further cfg_commit requires a new load.
REQ-032 Outside WAIT and WRITE, samp_valid_out SHALL equal samp_valid_in combinationally.
REQ-033 Latency: commit at cycle T with samp_valid_in=0 at T+1 SHALL give writes in T+2..T+NTAPS+1 and swap_done at T+NTAPS+2.

Reset
REQ-034 Reset SHALL force IDLE, count=0, drop_cnt=0, and cfg_ready, cfg_err, busy, coef_we and swap_done all 0.
REQ-035 Reset SHALL force coef_addr=0 and coef_data=0.
REQ-036 Reset mid-WRITE SHALL stop writes on the next cycle, produce no swap_done, and leave the shadow contents uncleared.

Configuration
REQ-037 With FIR_COEFF_SYM_EN defined, NLOAD SHALL be (NTAPS+1)/2 (26), and the word for address k SHALL be shadow[min(k, NTAPS-1-k)].
REQ-038 Without FIR_COEFF_SYM_EN, NLOAD SHALL be NTAPS, and the word for address k SHALL be shadow[k].

Structure
REQ-039 Package fir_pkg SHALL hold NTAPS, CW, AW, NLOAD and the FSM state typedef.
REQ-040 The shadow storage SHALL be sub-module fir_coeff_bank, with one write port, one read port and synchronous read; the controller SHALL compensate for the one-cycle read latency.

Verification
REQ-041 Load 0x0001..0x0033 then commit with samp_valid_in=0 -> 51 writes, addr 0..50, data 0x0001..0x0033, swap_done at T+53.
REQ-042 Commit after 10 words -> cfg_err pulse, state stays LOAD, no coef_we.
REQ-043 samp_valid_in held high 5 cycles after commit, then low, then 20 strobes during WRITE -> WRITE starts after the first low cycle, drop_cnt=20, samp_valid_out=0 throughout WRITE.
REQ-044 With FIR_COEFF_SYM_EN defined, load 26 words 0x0100..0x0119 -> addr 25 gets 0x0119, addr 50 gets 0x0100, addr 26 gets 0x0118.
REQ-045 Reset asserted at the 20th write -> coef_we low the next cycle, no swap_done; a subsequent commit without reload -> cfg_err.
REQ-046 cfg_start concurrent with an accepted cfg_valid at count 7 -> count=0 and that word is discarded.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared sizing and FSM state type for the FIR coefficient controller.
// Build option: FIR_COEFF_SYM_EN -- symmetric coefficient load (half bank, mirrored on transfer).
package fir_pkg;

  localparam int NTAPS = 51;
  localparam int CW    = 16;
  localparam int AW    = 6;

`ifdef FIR_COEFF_SYM_EN
  localparam int NLOAD = (NTAPS + 1) / 2;
`else
  localparam int NLOAD = NTAPS;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FULL  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: shadow coefficient storage, one write port, one synchronous read port.
// Contents are never cleared by reset; only the read register is.
module fir_coeff_bank #(
  parameter int DEPTH = fir_pkg::NLOAD,
  parameter int AW    = fir_pkg::AW,
  parameter int CW    = fir_pkg::CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [CW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [CW-1:0] o_rd_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_rd_data;

  // Storage write; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
      r_mem[i_wr_addr[IW-1:0]] <= i_wr_data;
    end
  end

  // Registered read, one cycle of latency; cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= (int'(i_rd_addr) < DEPTH) ? r_mem[i_rd_addr[IW-1:0]] : '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: loads coefficients into a shadow bank from the host, then on commit
// waits for a sample gap and streams the bank into the filter while blocking samples.
// Build option: FIR_COEFF_SYM_EN -- load only the first half of a symmetric response;
// address k is served from shadow[min(k, NTAPS-1-k)].
//
// state | meaning
// IDLE  | no load in progress; commit is rejected
// LOAD  | accepting host words into the shadow bank
// FULL  | shadow bank complete; waiting for commit
// WAIT  | commit accepted; waiting for a cycle with no sample strobe
// WRITE | streaming NTAPS coefficients to the filter, samples blocked
module fir_coeff_ctrl #(
  parameter int NTAPS = fir_pkg::NTAPS,
  parameter int CW    = fir_pkg::CW,
  parameter int AW    = fir_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_data,
  input  logic          cfg_commit,
  output logic          cfg_err,
  output logic          busy,
  input  logic          samp_valid_in,
  output logic          samp_valid_out,
  output logic          coef_we,
  output logic [AW-1:0] coef_addr,
  output logic [CW-1:0] coef_data,
  output logic          swap_done,
  output logic [7:0]    drop_cnt
);

  import fir_pkg::*;

`ifdef FIR_COEFF_SYM_EN
  localparam int NLOAD_L = (NTAPS + 1) / 2;
`else
  localparam int NLOAD_L = NTAPS;
`endif

  localparam logic [AW-1:0] LAST_ADDR = AW'(NTAPS - 1);
  localparam logic [AW-1:0] LAST_LOAD = AW'(NLOAD_L - 1);

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_cfg_ready;
  logic          r_cfg_err;
  logic          r_busy;
  logic          r_coef_we;
  logic [AW-1:0] r_coef_addr;
  logic          r_swap_done;
  logic [7:0]    r_drop_cnt;

  logic          w_bank_we;
  logic [AW-1:0] w_rd_k;
  logic [AW-1:0] w_rd_addr;
  logic [CW-1:0] w_rd_data;

  // A restart in the same cycle discards the host word.
  assign w_bank_we = (r_state == S_LOAD) && cfg_valid && !cfg_start;

  // The bank read is issued one tap ahead of the write on coef_*: tap 0 while waiting,
  // tap k+1 while tap k is being written.
  assign w_rd_k = ((r_state == S_WRITE) && (r_coef_addr != LAST_ADDR)) ?
                  r_coef_addr + 1'b1 : '0;

`ifdef FIR_COEFF_SYM_EN
  logic [AW-1:0] w_mirror;
  assign w_mirror  = LAST_ADDR - w_rd_k;
  assign w_rd_addr = (w_rd_k <= w_mirror) ? w_rd_k : w_mirror;
`else
  assign w_rd_addr = w_rd_k;
`endif

  fir_coeff_bank #(
    .DEPTH (NLOAD_L),
    .AW    (AW),
    .CW    (CW)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_bank_we),
    .i_wr_addr (r_cnt),
    .i_wr_data (cfg_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Sequencing FSM with registered status and coefficient-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cfg_ready <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_coef_we   <= 1'b0;
      r_coef_addr <= '0;
      r_swap_done <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_cfg_err   <= 1'b0;
      r_swap_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_commit) r_cfg_err <= 1'b1;
          if (cfg_start) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_cfg_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cfg_commit) r_cfg_err <= 1'b1;
          if (cfg_start) begin
            r_cnt <= '0;
          end else if (cfg_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_LOAD) begin
              r_state     <= S_FULL;
              r_cfg_ready <= 1'b0;
            end
          end
        end
        S_FULL: begin
          if (cfg_start) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_cfg_ready <= 1'b1;
          end else if (cfg_commit) begin
            r_state <= S_WAIT;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!samp_valid_in) begin
            r_state     <= S_WRITE;
            r_coef_we   <= 1'b1;
            r_coef_addr <= '0;
          end
        end
        S_WRITE: begin
          if (samp_valid_in && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
          if (r_coef_addr == LAST_ADDR) begin
            r_state     <= S_IDLE;
            r_coef_we   <= 1'b0;
            r_busy      <= 1'b0;
            r_swap_done <= 1'b1;
          end else begin
            r_coef_addr <= r_coef_addr + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign samp_valid_out = samp_valid_in && (r_state != S_WRITE);
  assign cfg_ready      = r_cfg_ready;
  assign cfg_err        = r_cfg_err;
  assign busy           = r_busy;
  assign coef_we        = r_coef_we;
  assign coef_addr      = r_coef_addr;
  assign coef_data      = w_rd_data;
  assign swap_done      = r_swap_done;
  assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Bench for fir_coeff_ctrl: directed sequence with random coefficient data and
// random strobe placement, checked against an array model of the shadow bank.
module tb_fir_coeff_ctrl;

  localparam int NTAPS = 51;
  localparam int CW    = 16;
  localparam int AW    = 6;
`ifdef FIR_COEFF_SYM_EN
  localparam int NLOAD = (NTAPS + 1) / 2;
`else
  localparam int NLOAD = NTAPS;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_data = '0;
  logic          cfg_commit = 1'b0;
  logic          cfg_err;
  logic          busy;
  logic          samp_valid_in = 1'b0;
  logic          samp_valid_out;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic          swap_done;
  logic [7:0]    drop_cnt;

  fir_coeff_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_data       (cfg_data),
    .cfg_commit     (cfg_commit),
    .cfg_err        (cfg_err),
    .busy           (busy),
    .samp_valid_in  (samp_valid_in),
    .samp_valid_out (samp_valid_out),
    .coef_we        (coef_we),
    .coef_addr      (coef_addr),
    .coef_data      (coef_data),
    .swap_done      (swap_done),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log of the filter-side port, read by the directed sequence.
  int            wr_addr_q[$];
  logic [CW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            swap_q[$];
  int            svo_leak = 0;

  always @(negedge clk) begin
    if (coef_we) begin
      wr_addr_q.push_back(int'(coef_addr));
      wr_data_q.push_back(coef_data);
      wr_cyc_q.push_back(cyc);
    end
    if (swap_done) swap_q.push_back(cyc);
    if (coef_we && samp_valid_out) svo_leak <= svo_leak + 1;
  end

  logic [CW-1:0] sh [64];
  int vectors     = 0;
  int miscompares = 0;
  int exp_drop    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] exp_word(input int k);
`ifdef FIR_COEFF_SYM_EN
    int j;
    j = (NTAPS - 1 - k < k) ? NTAPS - 1 - k : k;
    return sh[j];
`else
    return sh[k];
`endif
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    swap_q.delete();
  endtask

  task automatic load(input int n, input bit rnd, input logic [CW-1:0] base);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = rnd ? CW'($urandom) : base + CW'(i);
      sh[i]     = cfg_data;
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic transfer(input string tag, input int pre_high, input int n_strobe);
    int t;
    int need;
    int first;
    clear_log();
    samp_valid_in = 1'b0;
    cfg_commit    = 1'b1;
    t = cyc;
    tick();
    cfg_commit = 1'b0;
    for (int i = 0; i < pre_high; i++) begin
      samp_valid_in = 1'b1;
      #1;
      check($sformatf("%s_svo_wait%0d", tag, i), 32'(samp_valid_out), 32'd1);
      check($sformatf("%s_busy_wait%0d", tag, i), 32'(busy), 32'd1);
      tick();
    end
    samp_valid_in = 1'b0;
    tick();
    need = n_strobe;
    for (int i = 0; i < NTAPS; i++) begin
      samp_valid_in = (need > 0) && (int'($urandom_range(NTAPS - 1 - i, 0)) < need);
      if (samp_valid_in) need--;
      tick();
    end
    samp_valid_in = 1'b0;
    repeat (4) tick();
    first    = t + pre_high + 2;
    exp_drop = (exp_drop + n_strobe > 255) ? 255 : exp_drop + n_strobe;
    check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(NTAPS));
    for (int i = 0; i < wr_addr_q.size() && i < NTAPS; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(i));
      check($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[i]), 32'(exp_word(i)));
      check($sformatf("%s_wcyc%0d", tag, i), 32'(wr_cyc_q[i]), 32'(first + i));
    end
    check({tag, "_nswap"}, 32'(swap_q.size()), 32'd1);
    check({tag, "_swapcyc"}, 32'((swap_q.size() > 0) ? swap_q[0] : -1),
          32'(t + pre_high + NTAPS + 2));
    check({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
    check({tag, "_svo_leak"}, 32'(svo_leak), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    logic [CW-1:0] w;

    reset = 1'b1;
    repeat (3) tick();
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_cfg_err",   32'(cfg_err),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_coef_we",   32'(coef_we),   32'd0);
    check("rst_swap_done", 32'(swap_done), 32'd0);
    check("rst_coef_addr", 32'(coef_addr), 32'd0);
    check("rst_coef_data", 32'(coef_data), 32'd0);
    check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    reset = 1'b0;
    tick();

    samp_valid_in = 1'b1;
    #1;
    check("idle_svo_hi", 32'(samp_valid_out), 32'd1);
    samp_valid_in = 1'b0;
    #1;
    check("idle_svo_lo", 32'(samp_valid_out), 32'd0);

    // Ascending pattern, commit with an immediate sample gap.
    load(NLOAD, 1'b0, 16'h0001);
    check("full_ready", 32'(cfg_ready), 32'd0);
    transfer("basic", 0, 0);

`ifdef FIR_COEFF_SYM_EN
    load(NLOAD, 1'b0, 16'h0100);
    transfer("sym", 0, 0);
    check("sym_a25", 32'((wr_data_q.size() > 50) ? wr_data_q[25] : 16'hxxxx), 32'h0119);
    check("sym_a50", 32'((wr_data_q.size() > 50) ? wr_data_q[50] : 16'hxxxx), 32'h0100);
    check("sym_a26", 32'((wr_data_q.size() > 50) ? wr_data_q[26] : 16'hxxxx), 32'h0118);
`endif

    // A second commit without reloading is rejected.
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("recommit_err", 32'(cfg_err), 32'd1);
    check("recommit_busy", 32'(busy), 32'd0);
    tick();
    check("recommit_err_pulse", 32'(cfg_err), 32'd0);

    // Commit part-way through a load.
    clear_log();
    load(10, 1'b1, '0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("early_err", 32'(cfg_err), 32'd1);
    check("early_still_load", 32'(cfg_ready), 32'd1);
    tick();
    check("early_err_pulse", 32'(cfg_err), 32'd0);
    repeat (3) tick();
    check("early_nwrites", 32'(wr_addr_q.size()), 32'd0);
    check("early_busy", 32'(busy), 32'd0);

    // Restart at count 7 with a word offered in the same cycle: that word is lost.
    load(7, 1'b1, '0);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 16'hDEAD;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < NLOAD; i++) begin
      if (i == NLOAD - 1) check("restart_ready_last", 32'(cfg_ready), 32'd1);
      w         = CW'($urandom);
      cfg_valid = 1'b1;
      cfg_data  = w;
      sh[i]     = w;
      tick();
    end
    cfg_valid = 1'b0;
    check("restart_full", 32'(cfg_ready), 32'd0);

    // Strobes held for 5 cycles after commit, then 20 strobes during the write burst.
    transfer("strobe", 5, 20);

    // Drive drop_cnt into saturation.
    for (int r = 0; r < 5; r++) begin
      load(NLOAD, 1'b1, '0);
      transfer($sformatf("sat%0d", r), int'($urandom_range(3, 0)), NTAPS);
    end
    check("sat_final", 32'(drop_cnt), 32'd255);

    // Reset during the 20th write.
    load(NLOAD, 1'b1, '0);
    clear_log();
    samp_valid_in = 1'b0;
    cfg_commit    = 1'b1;
    t = cyc;
    tick();
    cfg_commit = 1'b0;
    tick();
    repeat (19) tick();
    check("rstw_we_before", 32'(coef_we), 32'd1);
    check("rstw_addr_before", 32'(coef_addr), 32'd19);
    check("rstw_cyc", 32'(cyc), 32'(t + 21));
    reset = 1'b1;
    tick();
    check("rstw_we_after", 32'(coef_we), 32'd0);
    check("rstw_addr_after", 32'(coef_addr), 32'd0);
    check("rstw_data_after", 32'(coef_data), 32'd0);
    check("rstw_busy_after", 32'(busy), 32'd0);
    check("rstw_drop_after", 32'(drop_cnt), 32'd0);
    exp_drop = 0;
    reset = 1'b0;
    repeat (60) tick();
    check("rstw_nwrites", 32'(wr_addr_q.size()), 32'd20);
    check("rstw_nswap", 32'(swap_q.size()), 32'd0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("rstw_commit_err", 32'(cfg_err), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
